// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - op_e    : load/store op encodings carried on req_op (4 bits)
//   - exc_e   : response exception codes carried on resp_exc (2 bits)
//   - state_e : access FSM states
//   - helpers : size_of, is_load, is_legal, is_misaligned, extend
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } op_e;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_ADEL    = 2'd1,
        EXC_ADES    = 2'd2,
        EXC_ILLEGAL = 2'd3
    } exc_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Access size in bytes; undefined ops report 1 so mask arithmetic stays sane.
    function automatic logic [2:0] size_of(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (size_of(op))
            3'd2:    return off[0];
            3'd4:    return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Buffer holds the access bytes starting at bit 0; stores yield zero.
    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] data);
        case (op)
            OP_LB:   return {{24{data[7]}}, data[7:0]};
            OP_LBU:  return {24'd0, data[7:0]};
            OP_LH:   return {{16{data[15]}}, data[15:0]};
            OP_LHU:  return {16'd0, data[15:0]};
            OP_LW:   return data;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/beat_lane_gen.sv
// beat_lane_gen: combinational per-beat lane generator.
//   op         in  access op (mem_pkg::op_e encoding)
//   offset     in  byte offset of the access within its 32-bit word
//   beat       in  beat index k of the access
//   wdata      in  store data, low bytes significant for SB/SH
//   be         out byte enables for beat k
//   lane_wdata out store data replicated across lanes (zero for loads)
module beat_lane_gen
    import mem_pkg::*;
#(
    parameter int unsigned BUS_BYTES = 4
) (
    input  logic [3:0]             op,
    input  logic [1:0]             offset,
    input  logic [1:0]             beat,
    input  logic [31:0]            wdata,
    output logic [BUS_BYTES-1:0]   be,
    output logic [8*BUS_BYTES-1:0] lane_wdata
);

    always_comb begin
        int unsigned size;
        int unsigned off;
        int unsigned base;
        int unsigned pos;
        int unsigned idx;
        be         = '0;
        lane_wdata = '0;
        size       = 32'(size_of(op));
        off        = 32'(offset);
        // Word position of lane 0 in this beat.
        base       = off - (off % BUS_BYTES) + 32'(beat) * BUS_BYTES;
        pos        = 0;
        idx        = 0;
        for (int unsigned i = 0; i < BUS_BYTES; i++) begin
            pos   = base + i;
            // Size is a power of two, so masking gives the replicated byte index.
            idx   = (32'(beat) * BUS_BYTES + i) & (size - 1);
            be[i] = (pos >= off) && (pos < off + size);
            if (!is_load(op)) begin
                lane_wdata[8*i +: 8] = wdata[8*idx +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-beat load/store unit between the MEM stage and a
// data bus of BUS_BYTES bytes (1, 2 or 4).
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (one request in flight)
//   req_op/req_addr/req_wdata  access op, byte address, store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata/resp_exc        extended load data, exception code
//   bus_valid/bus_ready        beat handshake
//   bus_we/bus_addr/bus_be     beat direction, aligned address, lane enables
//   bus_wdata/bus_rdata        lane data out / in
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned BUS_BYTES = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic [1:0]             resp_exc,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic                   bus_we,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [BUS_BYTES-1:0]   bus_be,
    output logic [8*BUS_BYTES-1:0] bus_wdata,
    input  logic [8*BUS_BYTES-1:0] bus_rdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(BUS_BYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BUS_BYTES);

    state_e                 state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [1:0]             off_q, off_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [1:0]             beat_q, beat_d;
    logic [31:0]            buf_q, buf_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic [1:0]             resp_exc_q, resp_exc_d;
    logic                   bus_valid_q, bus_valid_d;
    logic                   bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [BUS_BYTES-1:0]   bus_be_q, bus_be_d;
    logic [8*BUS_BYTES-1:0] bus_wdata_q, bus_wdata_d;

    logic [3:0]             gen_op;
    logic [1:0]             gen_off;
    logic [1:0]             gen_beat;
    logic [31:0]            gen_wdata;
    logic [BUS_BYTES-1:0]   gen_be;
    logic [8*BUS_BYTES-1:0] gen_lane_wdata;

    logic [2:0]             acc_size;
    logic [1:0]             last_idx;
    logic [31:0]            cap_buf;

    // One generator serves both the first beat (from the live request) and
    // every following beat (from the latched request), so outputs can be
    // registered one cycle ahead.
    always_comb begin
        if (state_q == ST_IDLE) begin
            gen_op    = req_op;
            gen_off   = req_addr[1:0];
            gen_beat  = 2'd0;
            gen_wdata = req_wdata;
        end else begin
            gen_op    = op_q;
            gen_off   = off_q;
            gen_beat  = beat_q + 2'd1;
            gen_wdata = wdata_q;
        end
    end

    beat_lane_gen #(
        .BUS_BYTES(BUS_BYTES)
    ) u_lane_gen (
        .op         (gen_op),
        .offset     (gen_off),
        .beat       (gen_beat),
        .wdata      (gen_wdata),
        .be         (gen_be),
        .lane_wdata (gen_lane_wdata)
    );

    // Last beat index and the buffer with the current beat's lanes merged in.
    always_comb begin
        int unsigned idx;
        acc_size = size_of(op_q);
        last_idx = (32'(acc_size) > BUS_BYTES) ? 2'(32'(acc_size) / BUS_BYTES - 1) : 2'd0;
        cap_buf  = buf_q;
        idx      = 0;
        for (int unsigned i = 0; i < BUS_BYTES; i++) begin
            if (bus_be_q[i]) begin
                idx = (32'(beat_q) * BUS_BYTES + i) & (32'(acc_size) - 1);
                cap_buf[8*idx +: 8] = bus_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_exc_d   = EXC_NONE;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    beat_d      = 2'd0;
                    buf_d       = '0;
                    req_ready_d = 1'b0;
                    if (!is_legal(req_op)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = EXC_ILLEGAL;
                    end else if (is_misaligned(req_op, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = is_load(req_op) ? EXC_ADEL : EXC_ADES;
                    end else begin
                        state_d     = ST_BUS;
                        bus_valid_d = 1'b1;
                        bus_we_d    = !is_load(req_op);
                        bus_addr_d  = req_addr & ALIGN_MASK;
                        bus_be_d    = gen_be;
                        bus_wdata_d = gen_lane_wdata;
                    end
                end
            end
            ST_BUS: begin
                if (bus_ready) begin
                    buf_d = cap_buf;
                    if (beat_q == last_idx) begin
                        state_d      = ST_RESP;
                        bus_valid_d  = 1'b0;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = '0;
                        bus_be_d     = '0;
                        bus_wdata_d  = '0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = extend(op_q, cap_buf);
                    end else begin
                        beat_d      = beat_q + 2'd1;
                        bus_addr_d  = bus_addr_q + BEAT_STRIDE;
                        bus_be_d    = gen_be;
                        bus_wdata_d = gen_lane_wdata;
                    end
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            buf_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_exc_q   <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            buf_q        <= buf_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = resp_exc_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (bus widths 4, 1, 2 bytes),
// a byte memory answering reads, and a per-instance response scoreboard.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] rd;
        logic [1:0]  exc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Index 0: BUS_BYTES=4, 1: BUS_BYTES=1, 2: BUS_BYTES=2
    logic        rst_n     [3];
    logic        req_valid [3];
    logic [3:0]  req_op    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        bus_ready [3];

    logic        rr0, rv0, bv0, bw0;
    logic [31:0] rd0, ba0, wd0, brd0;
    logic [1:0]  re0;
    logic [3:0]  be0;
    logic        rr1, rv1, bv1, bw1;
    logic [31:0] rd1, ba1;
    logic [1:0]  re1;
    logic [0:0]  be1;
    logic [7:0]  wd1, brd1;
    logic        rr2, rv2, bv2, bw2;
    logic [31:0] rd2, ba2;
    logic [1:0]  re2;
    logic [1:0]  be2;
    logic [15:0] wd2, brd2;

    logic        o_rdy [3];
    logic        o_rv  [3];
    logic [31:0] o_rd  [3];
    logic [1:0]  o_exc [3];
    logic        o_bv  [3];
    logic        o_bw  [3];
    logic [31:0] o_ba  [3];
    logic [3:0]  o_be  [3];
    logic [31:0] o_wd  [3];

    logic [7:0] mem [256];

    exp_t exp_q [3][$];
    exp_t mon_e;
    int   resp_cnt  [3];
    int   resp_cyc  [3];
    int   issue_cnt [3];

    mem_access_unit #(.BUS_BYTES(4), .ADDR_W(32)) u_bb4 (
        .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(rr0),
        .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_exc(re0),
        .bus_valid(bv0), .bus_ready(bus_ready[0]), .bus_we(bw0), .bus_addr(ba0),
        .bus_be(be0), .bus_wdata(wd0), .bus_rdata(brd0)
    );

    mem_access_unit #(.BUS_BYTES(1), .ADDR_W(32)) u_bb1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(rr1),
        .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_exc(re1),
        .bus_valid(bv1), .bus_ready(bus_ready[1]), .bus_we(bw1), .bus_addr(ba1),
        .bus_be(be1), .bus_wdata(wd1), .bus_rdata(brd1)
    );

    mem_access_unit #(.BUS_BYTES(2), .ADDR_W(32)) u_bb2 (
        .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(rr2),
        .req_op(req_op[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(rv2), .resp_rdata(rd2), .resp_exc(re2),
        .bus_valid(bv2), .bus_ready(bus_ready[2]), .bus_we(bw2), .bus_addr(ba2),
        .bus_be(be2), .bus_wdata(wd2), .bus_rdata(brd2)
    );

    // Read data from the byte memory (low address byte selects the cell).
    always_comb begin
        brd0 = {mem[8'(ba0 + 32'd3)], mem[8'(ba0 + 32'd2)], mem[8'(ba0 + 32'd1)], mem[8'(ba0)]};
        brd1 = mem[8'(ba1)];
        brd2 = {mem[8'(ba2 + 32'd1)], mem[8'(ba2)]};
    end

    always_comb begin
        o_rdy[0] = rr0;  o_rv[0] = rv0;  o_rd[0] = rd0;  o_exc[0] = re0;
        o_bv[0]  = bv0;  o_bw[0] = bw0;  o_ba[0] = ba0;  o_be[0]  = be0;  o_wd[0] = wd0;
        o_rdy[1] = rr1;  o_rv[1] = rv1;  o_rd[1] = rd1;  o_exc[1] = re1;
        o_bv[1]  = bv1;  o_bw[1] = bw1;  o_ba[1] = ba1;  o_be[1]  = 4'(be1);  o_wd[1] = 32'(wd1);
        o_rdy[2] = rr2;  o_rv[2] = rv2;  o_rd[2] = rd2;  o_exc[2] = re2;
        o_bv[2]  = bv2;  o_bw[2] = bw2;  o_ba[2] = ba2;  o_be[2]  = 4'(be2);  o_wd[2] = 32'(wd2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response pulse pops one expected entry.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_rv[i]) begin
                resp_cnt[i]++;
                resp_cyc[i] = cyc;
                if (exp_q[i].size() == 0) begin
                    check_eq($sformatf("u%0d unexpected resp", i), 32'(exp_q[i].size()), 32'd1);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    check_eq($sformatf("u%0d resp_rdata", i), o_rd[i], mon_e.rd);
                    check_eq($sformatf("u%0d resp_exc", i), 32'(o_exc[i]), 32'(mon_e.exc));
                end
            end
        end
    end

    // Offers a request and returns just after its handshake edge.
    task automatic issue(input int inst, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic [1:0] exp_exc, input bit push, input bit keep,
                         output int hs);
        exp_t e;
        int   waited;
        @(negedge clk);
        req_op[inst]    = op;
        req_addr[inst]  = addr;
        req_wdata[inst] = wdata;
        req_valid[inst] = 1'b1;
        if (push) begin
            e.rd  = exp_rd;
            e.exc = exp_exc;
            exp_q[inst].push_back(e);
        end
        waited = 0;
        while (!o_rdy[inst] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!o_rdy[inst]) check_eq($sformatf("u%0d req_ready timeout", inst), 32'(o_rdy[inst]), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid[inst] = 1'b0;
        hs = cyc;
        issue_cnt[inst] = resp_cnt[inst];
    endtask

    task automatic await_resp(input int inst, input int hs, input int lat, input string tag);
        int n;
        n = 0;
        while (resp_cnt[inst] == issue_cnt[inst] && n < 40) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, " resp count"}, 32'(resp_cnt[inst]), 32'(issue_cnt[inst] + 1));
        check_eq({tag, " latency"}, 32'(resp_cyc[inst] - hs), 32'(lat));
    endtask

    task automatic bus_chk(input int inst, input string tag, input logic [31:0] addr,
                           input logic [3:0] be, input logic we, input logic [31:0] wd);
        check_eq({tag, " bus_valid"}, 32'(o_bv[inst]), 32'd1);
        check_eq({tag, " bus_we"}, 32'(o_bw[inst]), 32'(we));
        check_eq({tag, " bus_addr"}, o_ba[inst], addr);
        check_eq({tag, " bus_be"}, 32'(o_be[inst]), 32'(be));
        if (we) check_eq({tag, " bus_wdata"}, o_wd[inst], wd);
    endtask

    task automatic set_word(input logic [31:0] w);
        mem[0] = w[7:0];
        mem[1] = w[15:8];
        mem[2] = w[23:16];
        mem[3] = w[31:24];
    endtask

    initial begin
        int hs;
        int hs2;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;  req_valid[i] = 1'b0;  req_op[i] = '0;
            req_addr[i] = '0; req_wdata[i] = '0;    bus_ready[i] = 1'b1;
            resp_cnt[i] = 0;  resp_cyc[i] = 0;      issue_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Reset values
        @(negedge clk);
        check_eq("rst req_ready", 32'(o_rdy[0]), 32'd1);
        check_eq("rst resp_valid", 32'(o_rv[0]), 32'd0);
        check_eq("rst resp_rdata", o_rd[0], 32'd0);
        check_eq("rst resp_exc", 32'(o_exc[0]), 32'd0);
        check_eq("rst bus_valid", 32'(o_bv[0]), 32'd0);
        check_eq("rst bus_we", 32'(o_bw[0]), 32'd0);
        check_eq("rst bus_addr", o_ba[0], 32'd0);
        check_eq("rst bus_be", 32'(o_be[0]), 32'd0);
        check_eq("rst bus_wdata", o_wd[0], 32'd0);
        check_eq("rst u1 req_ready", 32'(o_rdy[1]), 32'd1);
        check_eq("rst u2 req_ready", 32'(o_rdy[2]), 32'd1);

        // 4-byte bus: SB to 0x1003
        issue(0, OP_SB, 32'h1003, 32'h0000_00AB, 32'h0, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(0, "sb", 32'h1000, 4'b1000, 1'b1, 32'hABAB_ABAB);
        await_resp(0, hs, 1, "sb");

        // 4-byte bus: LH / LHU from 0x2002
        set_word(32'h8001_1234);
        issue(0, OP_LH, 32'h2002, 32'h0, 32'hFFFF_8001, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(0, "lh", 32'h2000, 4'b1100, 1'b0, 32'h0);
        await_resp(0, hs, 1, "lh");
        issue(0, OP_LHU, 32'h2002, 32'h0, 32'h0000_8001, EXC_NONE, 1'b1, 1'b0, hs);
        await_resp(0, hs, 1, "lhu");

        // Faulting accesses
        issue(0, OP_SW, 32'h0102, 32'h1234_5678, 32'h0, EXC_ADES, 1'b1, 1'b0, hs);
        @(negedge clk);
        check_eq("sw misaligned bus_valid", 32'(o_bv[0]), 32'd0);
        await_resp(0, hs, 0, "sw misaligned");
        issue(0, OP_LH, 32'h2001, 32'h0, 32'h0, EXC_ADEL, 1'b1, 1'b0, hs);
        await_resp(0, hs, 0, "lh misaligned");
        issue(0, 4'hF, 32'h2000, 32'h0, 32'h0, EXC_ILLEGAL, 1'b1, 1'b0, hs);
        await_resp(0, hs, 0, "illegal op");

        // 1-byte bus: LW from 0x100 with two stall cycles on beat 1
        set_word(32'h4433_2211);
        issue(1, OP_LW, 32'h0100, 32'h0, 32'h4433_2211, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(1, "lw1 beat0", 32'h0100, 4'b0001, 1'b0, 32'h0);
        @(posedge clk);
        #1 bus_ready[1] = 1'b0;
        @(negedge clk);
        bus_chk(1, "lw1 beat1", 32'h0101, 4'b0001, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus_chk(1, "lw1 stall", 32'h0101, 4'b0001, 1'b0, 32'h0);
        @(posedge clk);
        #1 bus_ready[1] = 1'b1;
        @(negedge clk);
        check_eq("lw1 stall2 bus_addr", o_ba[1], 32'h0101);
        await_resp(1, hs, 6, "lw1");

        // 1-byte bus: SH to 0x102 carries one byte per beat
        issue(1, OP_SH, 32'h0102, 32'h0000_CAFE, 32'h0, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(1, "sh1 beat0", 32'h0102, 4'b0001, 1'b1, 32'h0000_00FE);
        @(negedge clk);
        bus_chk(1, "sh1 beat1", 32'h0103, 4'b0001, 1'b1, 32'h0000_00CA);
        await_resp(1, hs, 2, "sh1");

        // 2-byte bus: reset during beat 1 drops the access
        set_word(32'h8001_1234);
        issue(2, OP_LW, 32'h0200, 32'h0, 32'h0, EXC_NONE, 1'b0, 1'b0, hs);
        @(negedge clk);
        bus_chk(2, "rst lw beat0", 32'h0200, 4'b0011, 1'b0, 32'h0);
        @(posedge clk);
        #1 rst_n[2] = 1'b0;
        @(negedge clk);
        check_eq("rst lw beat1 bus_addr", o_ba[2], 32'h0202);
        @(posedge clk);
        #1 rst_n[2] = 1'b1;
        @(negedge clk);
        check_eq("after rst bus_valid", 32'(o_bv[2]), 32'd0);
        check_eq("after rst req_ready", 32'(o_rdy[2]), 32'd1);
        check_eq("after rst bus_addr", o_ba[2], 32'd0);
        repeat (4) @(negedge clk);
        check_eq("after rst no resp", 32'(resp_cnt[2]), 32'(issue_cnt[2]));

        // 2-byte bus: normal traffic after reset
        issue(2, OP_SH, 32'h0206, 32'h0000_BEEF, 32'h0, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(2, "sh2", 32'h0206, 4'b0011, 1'b1, 32'h0000_BEEF);
        await_resp(2, hs, 1, "sh2");
        issue(2, OP_SB, 32'h0201, 32'h0000_005A, 32'h0, EXC_NONE, 1'b1, 1'b0, hs);
        @(negedge clk);
        bus_chk(2, "sb2", 32'h0200, 4'b0010, 1'b1, 32'h0000_5A5A);
        await_resp(2, hs, 1, "sb2");
        issue(2, OP_LW, 32'h0200, 32'h0, 32'h8001_1234, EXC_NONE, 1'b1, 1'b0, hs);
        await_resp(2, hs, 2, "lw2");

        // 4-byte bus: req_valid held high across a busy period
        set_word(32'h80FF_FF7F);
        issue(0, OP_LB, 32'h3003, 32'h0, 32'hFFFF_FF80, EXC_NONE, 1'b1, 1'b1, hs);
        req_op[0]   = OP_LBU;
        req_addr[0] = 32'h3003;
        exp_q[0].push_back('{rd: 32'h0000_0080, exc: EXC_NONE});
        @(negedge clk);
        check_eq("b2b ready in BUS", 32'(o_rdy[0]), 32'd0);
        @(negedge clk);
        check_eq("b2b ready in RESP", 32'(o_rdy[0]), 32'd0);
        check_eq("b2b resp_valid", 32'(o_rv[0]), 32'd1);
        @(negedge clk);
        check_eq("b2b ready back", 32'(o_rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        hs2 = cyc;
        issue_cnt[0] = resp_cnt[0];
        check_eq("b2b spacing", 32'(hs2 - hs), 32'd3);
        await_resp(0, hs2, 1, "b2b second");

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d scoreboard drained", i), 32'(exp_q[i].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got time %0t, expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, multi-beat data-memory access unit for the pipelined MIPS core, and the successor to the single-cycle byte-enable decoder. It accepts one load/store request at a time from the MEM stage and splits it into one or more beats on a data bus of configurable width. For each beat it generates the byte enables and lane-replicated store data. It assembles and sign/zero-extends load data, traps misaligned or illegal accesses without touching the bus, and returns one response pulse per request.

## Interface
- BUS_BYTES, 4, data-bus width in bytes; legal values 1, 2, 4.
- ADDR_W, 32, address width.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state.
- req_valid  in  1  request offered.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  4  access op: LB, LBU, LH, LHU, LW, SB, SH, SW; encoding in shared package.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  2  0 none, 1 AdEL, 2 AdES, 3 illegal op.
- bus_valid  out  1  beat offered.
- bus_ready  in  1  beat completes when bus_valid && bus_ready.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  beat address, aligned to BUS_BYTES.
- bus_be  out  BUS_BYTES  active byte lanes of the beat.
- bus_wdata  out  8*BUS_BYTES  store data on lanes.
- bus_rdata  in  8*BUS_BYTES  read data, sampled at the completing edge.

## Operation
- Byte order is little-endian: lane i carries the byte at bus_addr+i.
- Access size S is 1 (B/BU), 2 (H/HU) or 4 (W).
- Beat count is NB = max(1, S/BUS_BYTES).
- Beat k address is (req_addr aligned down to BUS_BYTES) + k*BUS_BYTES.
- Beat k enables exactly the lanes covered by the access. With BUS_BYTES=4: SB sets bit addr[1:0], SH sets 0011 or 1100 by addr[1], SW sets 1111.
- Store data is the S-byte value replicated across all lanes. On a narrower bus, beat k carries bytes k*BUS_BYTES upward.
- Load bytes are taken from the enabled lanes into an internal 32-bit buffer at their byte offset. On the last beat the result is sign-extended (LB, LH) or zero-extended (LBU, LHU).
- Misalignment rules:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0: exception with no bus activity.
  - Loads report AdEL; stores report AdES.
  - Undefined req_op reports exc 3.
- FSM states:
  - IDLE: req_ready=1. A handshake latches op, addr and wdata. Next state is BUS for a legal access, RESP for a faulting one.
  - BUS: bus_valid=1; beat outputs stable until bus_ready. On completion, capture read lanes. Go to RESP if k=NB-1, else increment k.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- req_ready=0 in BUS and RESP. There is no response backpressure.

## Timing
- Reset values of all outputs: req_ready=1 after the reset edge; resp_valid, bus_valid, bus_we, bus_be, resp_exc = 0; resp_rdata, bus_addr, bus_wdata = 0. State is IDLE, beat counter is 0.
- Handshake at edge N, legal access, zero-stall bus:
  - beat k is offered in cycle N+1+k;
  - resp_valid in cycle N+1+NB;
  - req_ready returns in cycle N+2+NB.
- Faulting access: resp_valid in cycle N+1.
- Each cycle with bus_ready=0 adds one cycle of latency. The outputs of a stalled beat stay stable.
- Reset low during any state: at the next edge all outputs return to reset values. The in-flight beat is dropped and no resp_valid is issued for it.
- Minimum spacing between accepted requests is NB+2 cycles.

## Structure
- Shared package mem_pkg holds:
  - op encodings and exc codes;
  - FSM state enum;
  - size_of(op), is_load(op) and is_legal(op) functions.
- Sub-module beat_lane_gen (combinational) produces bus_be and bus_wdata from op, the aligned offset, beat index and BUS_BYTES. The FSM, capture buffer and extension logic live in the top level.

## Test plan
- BUS_BYTES=4, SB to 0x1003, wdata 0x000000AB:
  - bus_addr 0x1000, bus_be 1000, bus_wdata 0xABABABAB, bus_we=1;
  - resp_valid at N+2, exc 0.
- BUS_BYTES=4, LH from 0x2002, bus_rdata 0x8001_1234 → resp_rdata 0xFFFF8001. LHU with the same data → 0x00008001.
- BUS_BYTES=1, LW from 0x100, bytes 0x11/0x22/0x33/0x44:
  - 4 beats at 0x100–0x103; bus_ready held low 2 cycles on beat 1;
  - bus_addr holds 0x101 during the stall;
  - resp_rdata 0x44332211 at N+7.
- SW to 0x102 → no bus_valid, resp_exc=2 at N+1. LH from 0x2001 → resp_exc=1. Undefined op → resp_exc=3.
- BUS_BYTES=2, LW from 0x200, reset driven low during beat 1 → bus_valid=0 on the next cycle, no resp_valid, req_ready=1 after reset releases.
- req_valid held high across a busy period → req_ready=0 through BUS and RESP. The second request is accepted in the cycle after resp_valid.
